aes128_key_sched: RTL and testbench
===================================

// Module: aes128_key_sched
// PURPOSE
//  Iterative AES-128 key expansion: turns the cipher key into round keys 0..10, one per advance step.
//  Sits directly upstream of the add-round-key stage and drives its key inputs:
//   - key 0 goes to key_in;
//   - keys 1..10 go to ksch_key_in.
//  The round counter tracks the consumer's round number.
//  The sequencing controller requests each next key with a one-cycle pulse.
// PARAMETERS
//  KEY_W   128  key/round-key width; only 128 is supported
//  NR      10   number of rounds; last key index
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  key_in     in   128    cipher key; w0 = [127:96] .. w3 = [31:0]; sampled on load_in
//  load_in    in   1      start pulse: capture key_in, publish round key 0
//  next_in    in   1      advance pulse: publish the next round key
//  rkey_out   out  128    current round key
//  round_out  out  4      index of rkey_out, 0..NR
//  valid_out  out  1      rkey_out/round_out are meaningful
//  busy_out   out  1      schedule in progress (state != IDLE)
//  done_out   out  1      one-cycle pulse: key NR has been consumed
// BEHAVIOUR
//  Reset (sync, rst=1 at a clk edge): all outputs 0, state IDLE, rcon register = 8'h01.
//   - Overrides load_in/next_in in the same cycle.
//   - Reset mid-schedule aborts the schedule; no done_out.
//  States: IDLE -> ACTIVE -> (DONE) -> IDLE.
//  IDLE: load_in=1 -> next edge: rkey_out=key_in, round_out=0, valid_out=1, busy_out=1, rcon=01, state ACTIVE.
//   - next_in is ignored in IDLE.
//  ACTIVE, next_in=1, round_out<NR -> next edge:
//   - rkey_out = expand(rkey_out, rcon);
//   - round_out += 1;
//   - rcon = xtime(rcon) (01,02,04,08,10,20,40,80,1b,36).
//  Advance latency is one cycle; back-to-back next_in pulses advance once per cycle.
//  ACTIVE, next_in=1, round_out==NR -> next edge: done_out=1, valid_out=0, busy_out=0, round_out=0.
//   - rkey_out holds its last value; state DONE for one cycle, then IDLE with done_out=0.
//  No next_in in ACTIVE: all outputs hold; there is no timeout.
//  expand(w0..w3, rc):
//   - t  = SubWord(RotWord(w3)) ^ {rc,24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a};
//   - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
//   - Purely combinational from the rkey_out register, with 4 S-box lookups; no other arithmetic.
//  load_in in ACTIVE or DONE: restart.
//   - Same update as in IDLE; the current schedule is discarded; no done_out.
//  load_in and next_in in the same cycle: load_in wins; next_in is dropped.
//  round_out never exceeds NR, and rcon never advances past 8'h36.
//  No combinational path from any input to any output.
// STRUCTURE
//  Shared package aes_pkg:
//   - AES_NR = 10;
//   - state encoding localparams (ST_IDLE, ST_ACTIVE, ST_DONE);
//   - xtime function;
//   - RCON_INIT = 8'h01.
//  The same package is used by the round-sequencing controller and the add-round-key stage.
//  Sub-module aes_sbox: combinational 8-bit forward S-box, case-table ROM.
//   - Instantiated 4x for SubWord; shared later with the SubBytes stage.
//  Top level: state register, round counter, rcon register, 128-bit key register, expand logic.
// TESTING
//  1. FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, load, then next x1
//     -> round 1 = a0fafe17_88542cb1_23a33939_2a6c7605.
//  2. Same key, next x10 back-to-back -> round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
//     One more next -> done_out=1 for exactly 1 cycle; busy_out=0; valid_out=0.
//  3. All-zero key, load, then next x1 -> round 1 = 62636363_62636363_62636363_62636363 (rcon 01 path).
//  4. FIPS key, advance to round 5; load all-zero key with next_in=1 in the same cycle
//     -> round_out=0, rkey_out=0; next round 1 = 62636363_x4.
//  5. rst=1 at round 7 -> next edge: all outputs 0, state IDLE.
//     A following next_in has no effect; a load_in then works normally.
//  6. Gaps of 0..5 idle cycles between next_in pulses -> outputs stable during gaps.
//     The key sequence matches the reference model for 1k random keys.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule, round sequencer and add-round-key stage.
package aes_pkg;

    localparam int AES_NR = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_LAST = 8'h36;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_sched_if.sv
// Key-schedule control/data bundle between the round sequencer (master) and the key schedule (slave).
interface aes128_key_sched_if #(
    parameter int KEY_W = 128
);
    logic [KEY_W-1:0] key_in;
    logic             load_in;
    logic             next_in;
    logic [KEY_W-1:0] rkey_out;
    logic [3:0]       round_out;
    logic             valid_out;
    logic             busy_out;
    logic             done_out;

    modport master (
        output key_in, load_in, next_in,
        input  rkey_out, round_out, valid_out, busy_out, done_out
    );

    modport slave (
        input  key_in, load_in, next_in,
        output rkey_out, round_out, valid_out, busy_out, done_out
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box as a case-table ROM.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    always_comb begin
        s = '0;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
    end
endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key expansion: publishes round keys 0..NR, one per next_in pulse.
module aes128_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_W = 128,
    parameter int NR    = AES_NR
) (
    input  logic               clk,
    input  logic               rst,
    aes128_key_sched_if.slave  ks
);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [1:0]       st_q;
    logic [3:0]       round_q;
    logic [7:0]       rcon_q;
    logic [KEY_W-1:0] key_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [31:0]      rot_w;
    logic [31:0]      sub_w;
    logic [31:0]      t_w;
    logic [31:0]      w0_n, w1_n, w2_n, w3_n;

    // RotWord of w3, then SubWord through four S-box instances.
    assign rot_w = {key_q[23:0], key_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot_w[i*8 +: 8]),
            .s (sub_w[i*8 +: 8])
        );
    end

    always_comb begin
        t_w  = sub_w ^ {rcon_q, 24'h0};
        w0_n = key_q[127:96] ^ t_w;
        w1_n = key_q[95:64]  ^ w0_n;
        w2_n = key_q[63:32]  ^ w1_n;
        w3_n = key_q[31:0]   ^ w2_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            key_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // load_in restarts from any state and masks a coincident next_in.
            if (ks.load_in) begin
                st_q    <= ST_ACTIVE;
                round_q <= '0;
                rcon_q  <= RCON_INIT;
                key_q   <= ks.key_in;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                case (st_q)
                    ST_ACTIVE: begin
                        if (ks.next_in) begin
                            if (round_q < LAST_ROUND) begin
                                key_q   <= {w0_n, w1_n, w2_n, w3_n};
                                round_q <= round_q + 4'd1;
                                rcon_q  <= (rcon_q == RCON_LAST) ? rcon_q : xtime(rcon_q);
                            end else begin
                                st_q    <= ST_DONE;
                                round_q <= '0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: st_q <= ST_IDLE;
                    default: st_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ks.rkey_out  = key_q;
    assign ks.round_out = round_q;
    assign ks.valid_out = valid_q;
    assign ks.busy_out  = busy_q;
    assign ks.done_out  = done_q;

endmodule

// File: tb/tb_aes128_key_sched.sv
// Directed and randomised checks of the AES-128 key schedule against an independent model.
module tb_aes128_key_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes128_key_sched_if ks_if ();

    aes128_key_sched dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] sb [256];
    logic [7:0] rc_tab [10];

    typedef struct {
        logic [127:0] key;
        int unsigned  rnd;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [6];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] ZERO_R1  = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box derived from GF(2^8) inversion and the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [127:0] m_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, rot, t, a, b, c, d;
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sb[rot[31:24]], sb[rot[23:16]], sb[rot[15:8]], sb[rot[7:0]]} ^ {rc, 24'h0};
        a   = k[127:96] ^ t;
        b   = k[95:64] ^ a;
        c   = k[63:32] ^ b;
        d   = k[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    task automatic do_load(input logic [127:0] key, input logic with_next);
        ks_if.key_in  = key;
        ks_if.load_in = 1'b1;
        ks_if.next_in = with_next;
        @(negedge clk);
        ks_if.load_in = 1'b0;
        ks_if.next_in = 1'b0;
    endtask

    task automatic do_next(input int unsigned n);
        ks_if.next_in = 1'b1;
        repeat (n) @(negedge clk);
        ks_if.next_in = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_rkey"},  ks_if.rkey_out, '0);
        chk({tag, "_round"}, 128'(ks_if.round_out), '0);
        chk({tag, "_valid"}, 128'(ks_if.valid_out), '0);
        chk({tag, "_busy"},  128'(ks_if.busy_out), '0);
        chk({tag, "_done"},  128'(ks_if.done_out), '0);
    endtask

    initial begin
        logic [127:0] key, exp;
        ks_if.key_in  = '0;
        ks_if.load_in = 1'b0;
        ks_if.next_in = 1'b0;
        build_sbox();

        vecs[0] = '{FIPS_KEY, 0,  FIPS_KEY};
        vecs[1] = '{FIPS_KEY, 1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605};
        vecs[2] = '{FIPS_KEY, 2,  128'hf2c295f2_7a96b943_5935807a_7359f67f};
        vecs[3] = '{FIPS_KEY, 10, FIPS_R10};
        vecs[4] = '{128'h0,   1,  ZERO_R1};
        vecs[5] = '{128'h0,   2,  128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("reset");

        // Table vectors: load, then back-to-back advances.
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].key, 1'b0);
            if (vecs[i].rnd != 0) do_next(vecs[i].rnd);
            chk($sformatf("vec%0d_rkey", i),  ks_if.rkey_out, vecs[i].exp);
            chk($sformatf("vec%0d_round", i), 128'(ks_if.round_out), 128'(vecs[i].rnd));
            chk($sformatf("vec%0d_valid", i), 128'(ks_if.valid_out), 128'd1);
        end

        // Past the last key: one-cycle done, key held.
        do_load(FIPS_KEY, 1'b0);
        do_next(10);
        chk("r10_done_low", 128'(ks_if.done_out), '0);
        chk("r10_busy",     128'(ks_if.busy_out), 128'd1);
        do_next(1);
        chk("done_pulse", 128'(ks_if.done_out), 128'd1);
        chk("done_busy",  128'(ks_if.busy_out), '0);
        chk("done_valid", 128'(ks_if.valid_out), '0);
        chk("done_round", 128'(ks_if.round_out), '0);
        chk("done_rkey",  ks_if.rkey_out, FIPS_R10);
        @(negedge clk);
        chk("done_once", 128'(ks_if.done_out), '0);
        do_next(1);
        chk("idle_next_ign_valid", 128'(ks_if.valid_out), '0);
        chk("idle_next_ign_done",  128'(ks_if.done_out), '0);

        // Restart with a coincident next_in mid-schedule.
        do_load(FIPS_KEY, 1'b0);
        do_next(5);
        chk("pre_restart_round", 128'(ks_if.round_out), 128'd5);
        do_load('0, 1'b1);
        chk("restart_round", 128'(ks_if.round_out), '0);
        chk("restart_rkey",  ks_if.rkey_out, '0);
        chk("restart_done",  128'(ks_if.done_out), '0);
        do_next(1);
        chk("restart_r1", ks_if.rkey_out, ZERO_R1);

        // Reset mid-schedule, then next ignored, then load works.
        do_load(FIPS_KEY, 1'b0);
        do_next(6);
        ks_if.next_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ks_if.next_in = 1'b0;
        chk_idle_zero("rst_mid");
        do_next(1);
        chk_idle_zero("rst_next");
        do_load(FIPS_KEY, 1'b0);
        chk("rst_load_rkey",  ks_if.rkey_out, FIPS_KEY);
        chk("rst_load_busy",  128'(ks_if.busy_out), 128'd1);
        do_next(1);
        chk("rst_load_r1", ks_if.rkey_out, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);

        // Random keys with idle gaps between advances.
        for (int k = 0; k < 1000; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            do_load(key, 1'b0);
            exp = key;
            chk("rnd_r0", ks_if.rkey_out, exp);
            for (int r = 1; r <= 10; r++) begin
                repeat ($urandom_range(0, 5)) begin
                    @(negedge clk);
                    chk("gap_rkey",  ks_if.rkey_out, exp);
                    chk("gap_round", 128'(ks_if.round_out), 128'(r - 1));
                end
                do_next(1);
                exp = m_expand(exp, rc_tab[r-1]);
                chk($sformatf("rnd_key%0d_r%0d", k, r), ks_if.rkey_out, exp);
                chk("rnd_round", 128'(ks_if.round_out), 128'(r));
            end
            do_next(1);
            chk("rnd_done", 128'(ks_if.done_out), 128'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
